// File: rtl/wave_dma_mixer_if.sv
// Sample-fetch memory port of wave_dma_mixer: the mixer is the master, memory is the slave.
// O_MEM_RD is a level request held until I_MEM_READY; I_MEM_DATA is valid in the READY cycle.
interface wave_dma_mixer_if #(
  parameter int AW = 28
) ();
  logic [AW-1:0] O_MEM_ADDR;
  logic          O_MEM_RD;
  logic          I_MEM_READY;
  logic [7:0]    I_MEM_DATA;

  modport master (output O_MEM_ADDR, O_MEM_RD, input I_MEM_READY, I_MEM_DATA);
  modport slave  (input O_MEM_ADDR, O_MEM_RD, output I_MEM_READY, I_MEM_DATA);
endinterface

// File: rtl/wave_dma_mixer.sv
// Multi-channel 8-bit sample DMA player that mixes one byte per busy channel into a signed 16-bit output each tick.
// Define WAVE_DMA_MIXER_VOLUME_EN to add the per-channel 4-bit I_VOL gain input.
module wave_dma_mixer #(
  parameter int NCH     = 4,
  parameter int AW      = 28,
  parameter int LENW    = 16,
  parameter int CLK_DIV = 3000
) (
  input  logic                   I_CLK,
  input  logic                   I_RSTn,
  input  logic [NCH-1:0]         I_TRIG,
  input  logic [NCH-1:0]         I_STOP,
  input  logic [NCH-1:0]         I_LOOP,
  input  logic [NCH*AW-1:0]      I_START_ADDR,
  input  logic [NCH*LENW-1:0]    I_LEN,
`ifdef WAVE_DMA_MIXER_VOLUME_EN
  input  logic [NCH*4-1:0]       I_VOL,
`endif
  wave_dma_mixer_if.master       mem,
  output logic [NCH-1:0]         O_BUSY,
  output logic signed [15:0]     O_SND,
  output logic                   O_SAMPLE_STB,
  output logic                   O_OVERRUN
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = 20;
  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);
  localparam logic signed [SW-1:0] SAT_MAX = 20'sd32767;
  localparam logic signed [SW-1:0] SAT_MIN = -20'sd32768;

  typedef enum logic [1:0] {IDLE, SCAN, REQ, MIX} state_t;

  state_t state, next_state;

  logic [CW-1:0]          tick_cnt;
  logic                   tick;
  logic [IW-1:0]          idx;
  logic signed [SW-1:0]   acc;
  logic signed [SW-1:0]   term;
  logic signed [15:0]     sat;
  logic signed [8:0]      centered;
  logic [AW-1:0]          addr_q;
  logic                   req_kill;
  logic                   kill_now;
  logic                   capture;
  logic                   mem_rd;
  logic [NCH-1:0]         trig_ok;
  logic [NCH-1:0]         busy_q;
  logic [NCH-1:0]         loop_q;
  logic [AW-1:0]          start_q [NCH];
  logic [LENW-1:0]        len_q   [NCH];
  logic [LENW-1:0]        off_q   [NCH];
  logic signed [15:0]     snd_q;
  logic                   stb_q;
  logic                   ovr_q;
`ifdef WAVE_DMA_MIXER_VOLUME_EN
  logic [3:0]             vol_q   [NCH];
  logic signed [5:0]      gain;
  logic signed [14:0]     scaled;
`endif

  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      trig_ok[n] = I_TRIG[n] && (I_LEN[n*LENW +: LENW] != '0);
    end
  end

  // A stop or restart of the channel being fetched poisons the in-flight byte; it must not be mixed.
  assign kill_now = I_STOP[idx] | trig_ok[idx];
  assign capture  = (state == REQ) && mem.I_MEM_READY && !req_kill && !kill_now && busy_q[idx];

  always_ff @(posedge I_CLK) begin
    if (!I_RSTn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (tick) next_state = SCAN;
      SCAN: begin
        if (busy_q[idx])           next_state = REQ;
        else if (idx == IDX_LAST)  next_state = MIX;
      end
      REQ:  if (mem.I_MEM_READY)   next_state = (idx == IDX_LAST) ? MIX : SCAN;
      MIX:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_rd = (state == REQ);
  end

  always_comb begin
    centered = $signed({1'b0, mem.I_MEM_DATA}) - 9'sd128;
`ifdef WAVE_DMA_MIXER_VOLUME_EN
    gain   = $signed({2'b00, vol_q[idx]}) + 6'sd1;
    scaled = centered * gain;
    term   = {{(SW-19){scaled[14]}}, scaled, 4'b0000};
`else
    term   = {{(SW-17){centered[8]}}, centered, 8'h00};
`endif
  end

  always_comb begin
    if (acc > SAT_MAX)      sat = 16'sh7FFF;
    else if (acc < SAT_MIN) sat = 16'sh8000;
    else                    sat = acc[15:0];
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RSTn) begin
      tick_cnt <= '0;
      idx      <= '0;
      acc      <= '0;
      addr_q   <= '0;
      req_kill <= 1'b0;
      snd_q    <= '0;
      stb_q    <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= '0;
      loop_q   <= '0;
      for (int n = 0; n < NCH; n++) begin
        start_q[n] <= '0;
        len_q[n]   <= '0;
        off_q[n]   <= '0;
`ifdef WAVE_DMA_MIXER_VOLUME_EN
        vol_q[n]   <= '0;
`endif
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      stb_q    <= 1'b0;
      ovr_q    <= tick && (state != IDLE);

      case (state)
        IDLE: begin
          if (tick) begin
            idx <= '0;
            acc <= '0;
          end
        end
        SCAN: begin
          if (busy_q[idx]) begin
            addr_q   <= start_q[idx] + AW'(off_q[idx]);
            req_kill <= 1'b0;
          end else if (idx != IDX_LAST) begin
            idx <= idx + 1'b1;
          end
        end
        REQ: begin
          if (kill_now) req_kill <= 1'b1;
          if (mem.I_MEM_READY) begin
            if (capture) acc <= acc + term;
            if (idx != IDX_LAST) idx <= idx + 1'b1;
          end
        end
        MIX: begin
          snd_q <= sat;
          stb_q <= 1'b1;
        end
        default: ;
      endcase

      // Trigger beats stop beats the end-of-sample bookkeeping of a captured byte.
      for (int n = 0; n < NCH; n++) begin
        if (trig_ok[n]) begin
          start_q[n] <= I_START_ADDR[n*AW +: AW];
          len_q[n]   <= I_LEN[n*LENW +: LENW];
          loop_q[n]  <= I_LOOP[n];
          off_q[n]   <= '0;
          busy_q[n]  <= 1'b1;
`ifdef WAVE_DMA_MIXER_VOLUME_EN
          vol_q[n]   <= I_VOL[n*4 +: 4];
`endif
        end else if (I_STOP[n]) begin
          busy_q[n] <= 1'b0;
        end else if (capture && (idx == IW'(n))) begin
          if (off_q[n] + 1'b1 == len_q[n]) begin
            off_q[n] <= '0;
            if (!loop_q[n]) busy_q[n] <= 1'b0;
          end else begin
            off_q[n] <= off_q[n] + 1'b1;
          end
        end
      end
    end
  end

  assign mem.O_MEM_ADDR = addr_q;
  assign mem.O_MEM_RD   = mem_rd;
  assign O_BUSY         = busy_q;
  assign O_SND          = snd_q;
  assign O_SAMPLE_STB   = stb_q;
  assign O_OVERRUN      = ovr_q;

endmodule

// File: doc/wave_dma_mixer.md
WAVE_DMA_MIXER -- requirements
Module: wave_dma_mixer

Interface
REQ-001 Parameter NCH, default 4: channel count, 1..8.
REQ-002 Parameter AW, default 28: memory byte-address width.
REQ-003 Parameter LENW, default 16: sample-length width in bytes.
REQ-004 Parameter CLK_DIV, default 3000: clocks per output sample (24 MHz / 8 kHz).
REQ-005 I_CLK  in  1  system clock; the only clock in the block.
REQ-006 I_RSTn  in  1  reset, synchronous to I_CLK, active-low.
REQ-007 I_TRIG  in  NCH  per-channel start pulse, one cycle.
REQ-008 I_STOP  in  NCH  per-channel stop pulse, one cycle.
REQ-009 I_LOOP  in  NCH  per-channel loop enable, sampled on trigger.
REQ-010 I_START_ADDR  in  NCH*AW  per-channel start byte address, channel n at bits [n*AW +: AW], sampled on trigger.
REQ-011 I_LEN  in  NCH*LENW  per-channel length in bytes, sampled on trigger.
REQ-012 O_MEM_ADDR  out  AW  fetch byte address.
REQ-013 O_MEM_RD  out  1  fetch request, level.
REQ-014 I_MEM_READY  in  1  fetch acknowledge; I_MEM_DATA valid in the same cycle.
REQ-015 I_MEM_DATA  in  8  unsigned 8-bit sample byte.
REQ-016 O_BUSY  out  NCH  channel active.
REQ-017 O_SND  out  16  signed mixed sample.
REQ-018 O_SAMPLE_STB  out  1  one-cycle pulse when O_SND updates.
REQ-019 O_OVERRUN  out  1  one-cycle pulse when a sample tick is dropped.

Function
REQ-020 Tick counter SHALL count 0..CLK_DIV-1 and wrap; the tick is the cycle it equals CLK_DIV-1.
REQ-021 Trigger with LEN != 0 SHALL latch addr/len/loop, zero the byte offset and set O_BUSY[n] on the next cycle; trigger with LEN=0 is ignored.
REQ-022 Trigger on a busy channel SHALL restart it; trigger and stop in the same cycle: trigger wins.
REQ-023 Stop SHALL clear O_BUSY[n] next cycle; any in-flight fetch for n completes and its data is discarded (channel contributes 0).
REQ-024 Fetch FSM states: IDLE, SCAN, REQ, MIX. On tick in IDLE go to SCAN at channel 0; otherwise stay in IDLE.
REQ-025 SCAN: busy channel -> REQ for it; idle channel -> contributes 0, next index; after index NCH-1 -> MIX. One channel per cycle.
REQ-026 REQ: O_MEM_RD=1 with O_MEM_ADDR = start+offset held stable until I_MEM_READY=1; on that cycle capture data, drop O_MEM_RD next cycle, return to SCAN at the next index.
REQ-027 After a capture, offset increments; if offset reaches LEN: loop=1 -> offset=0; loop=0 -> O_BUSY[n] clears after this sample.
REQ-028 MIX (one cycle): term_n = (byte-128)<<8; sum all NCH terms at full width, saturate to [-32768, 32767], register to O_SND, pulse O_SAMPLE_STB, return to IDLE.
REQ-029 No busy channels at tick: O_SND=0, O_SAMPLE_STB still pulses.
REQ-030 Tick while FSM not in IDLE: tick dropped, O_OVERRUN pulses, current sequence continues unaffected.
REQ-031 O_MEM_ADDR SHALL wrap modulo 2^AW.

Reset
REQ-032 I_RSTn low at a clock edge: all outputs 0, FSM IDLE, tick counter 0, all channels idle, including during a pending REQ (O_MEM_RD drops next cycle).
REQ-033 The first tick after release occurs CLK_DIV cycles after the first cycle with I_RSTn high.

Configuration
REQ-034 Macro WAVE_DMA_MIXER_VOLUME_EN defined: adds input I_VOL (NCH*4, sampled on trigger); term_n = (byte-128)*(vol+1)<<4.
REQ-035 Macro not defined: no I_VOL port; term_n per REQ-028 (same as vol=15).

Verification
REQ-036 NCH=1, ch0 trig addr 0x100 len 3 loop 0, memory bytes 0x80,0xFF,0x00, READY 2 cycles after RD -> O_SND 0, 32512, -32768; reads at 0x100..0x102; O_BUSY[0] clears after third strobe.
REQ-037 Same with loop 1 -> 4th read at 0x100; O_BUSY stays 1.
REQ-038 NCH=4, all channels read 0xFF -> O_SND saturates to 32767; all read 0x00 -> -32768.
REQ-039 READY latency > CLK_DIV -> O_OVERRUN pulses once per dropped tick; O_MEM_ADDR stable while RD high.
REQ-040 Stop ch0 while its RD is pending -> fetch completes, O_SND=0 at next strobe, O_BUSY[0]=0.
REQ-041 I_RSTn low mid-REQ -> O_MEM_RD, O_BUSY, O_SND all 0 next cycle; no strobe until CLK_DIV cycles after release.
